// File: rtl/codec_buffer_rd_source.sv
// Read-side sequencer for the banked codec DWC buffer: walks the read
// address 0..len_m1 through the fixed-latency RAM port, repacks returned
// words into a sop/val/eop stream with ready backpressure, then releases
// the bank with a one-cycle orempty pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for ibuf_rdy; latches length and tag on start
// READ    | issuing one address per cycle while FIFO credit allows
// WAIT    | last address issued; waiting for its data to be captured
// RELEASE | orempty pulse, bank handed back to the buffer
// GAP     | guard cycle so the buffer's registered status settles
module codec_buffer_rd_source #(
  parameter int pRADDR_W = 8,
  parameter int pRDAT_W  = 8,
  parameter int pTAG_W   = 8,
  parameter int pPIPE    = 1
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  input  logic                ibuf_rdy,
  input  logic [pRADDR_W-1:0] ilen_m1,
  output logic [pRADDR_W-1:0] oraddr,
  input  logic [pRDAT_W-1:0]  irdat,
  input  logic [pTAG_W-1:0]   irtag,
  output logic                orempty,
  input  logic                ordy,
  output logic                oval,
  output logic                osop,
  output logic                oeop,
  output logic [pRDAT_W-1:0]  odat,
  output logic [pTAG_W-1:0]   otag,
  output logic                obusy
);

  localparam int LAT   = 1 + pPIPE;
  localparam int DEPTH = 4;

  typedef enum logic [2:0] {IDLE, READ, WAIT, RELEASE, GAP} state_t;

  state_t              state, state_nxt;
  logic [pRADDR_W-1:0] addr;
  logic [pRADDR_W-1:0] len_r;
  logic [pTAG_W-1:0]   tag_r;
  logic                start, issue, credit, wr_en, pop;

  // Read-latency tracking: one slot per RAM pipeline stage.
  logic                pipe_vld [LAT];
  logic                pipe_sop [LAT];
  logic                pipe_eop [LAT];
  logic [pTAG_W-1:0]   pipe_tag [LAT];
  logic [2:0]          inflight;

  // Output FIFO. The tag rides with each word so that a slow drain of one
  // block never sees the tag already latched for the next block.
  logic [pRDAT_W-1:0]  mem_dat [DEPTH];
  logic                mem_sop [DEPTH];
  logic                mem_eop [DEPTH];
  logic [pTAG_W-1:0]   mem_tag [DEPTH];
  logic [1:0]          wptr, rptr;
  logic [2:0]          fifo_cnt;

  assign credit = ({1'b0, fifo_cnt} + {1'b0, inflight}) < 4'(DEPTH);
  assign wr_en  = pipe_vld[LAT-1];
  assign oval   = (fifo_cnt != 3'd0);
  assign pop    = oval & ordy & iclkena;
  assign osop   = oval & mem_sop[rptr];
  assign oeop   = oval & mem_eop[rptr];
  assign odat   = oval ? mem_dat[rptr] : '0;
  assign oraddr = addr;
  assign obusy  = (state != IDLE);

  // State register.
  always_ff @(posedge iclk) begin
    if (ireset)       state <= IDLE;
    else if (iclkena) state <= state_nxt;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    issue     = 1'b0;
    orempty   = 1'b0;
    case (state)
      IDLE: begin
        if (ibuf_rdy) begin
          start     = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        if (credit) begin
          issue = 1'b1;
          if (addr == len_r) state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Leave as the last word is written so orempty follows its capture.
        if (inflight == 3'd0 || (inflight == 3'd1 && wr_en)) state_nxt = RELEASE;
      end
      RELEASE: begin
        orempty   = 1'b1;
        state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address counter, block length/tag latch and the latency pipeline.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      addr     <= '0;
      len_r    <= '0;
      tag_r    <= '0;
      inflight <= 3'd0;
      for (int i = 0; i < LAT; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_sop[i] <= 1'b0;
        pipe_eop[i] <= 1'b0;
        pipe_tag[i] <= '0;
      end
    end else if (iclkena) begin
      if (start) begin
        addr  <= '0;
        len_r <= ilen_m1;
        tag_r <= irtag;
      end else if (issue) begin
        addr <= addr + 1'b1;
      end
      pipe_vld[0] <= issue;
      pipe_sop[0] <= (addr == '0);
      pipe_eop[0] <= (addr == len_r);
      pipe_tag[0] <= tag_r;
      for (int i = 1; i < LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_sop[i] <= pipe_sop[i-1];
        pipe_eop[i] <= pipe_eop[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
      inflight <= inflight + {2'b00, issue} - {2'b00, wr_en};
    end
  end

  // Output FIFO write/read pointers and occupancy.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      wptr     <= 2'd0;
      rptr     <= 2'd0;
      fifo_cnt <= 3'd0;
    end else if (iclkena) begin
      if (wr_en) begin
        mem_dat[wptr] <= irdat;
        mem_sop[wptr] <= pipe_sop[LAT-1];
        mem_eop[wptr] <= pipe_eop[LAT-1];
        mem_tag[wptr] <= pipe_tag[LAT-1];
        wptr          <= wptr + 2'd1;
      end
      if (pop) rptr <= rptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b00, wr_en} - {2'b00, pop};
    end
  end

  // Block tag output: switches only when a block's first word leaves.
  always_ff @(posedge iclk) begin
    if (ireset)                      otag <= '0;
    else if (pop && mem_sop[rptr])   otag <= mem_tag[rptr];
  end

  // Credit should make a write into a full FIFO impossible.
  always_ff @(posedge iclk) begin
    if (!ireset && iclkena && wr_en) assert (fifo_cnt != 3'(DEPTH));
  end

endmodule

// File: tb/tb_codec_buffer_rd_source.sv
// Bench for codec_buffer_rd_source: a buffer/RAM model feeds blocks, a
// word-level scoreboard checks the framed stream, and fixed-timing runs
// check the cycle positions of the first block of each kind.
module tb_codec_buffer_rd_source;

  localparam int LAT = 2;

  typedef struct packed {
    logic [7:0] len;
    logic [7:0] tag;
    logic [7:0] base;
  } blk_t;

  typedef struct packed {
    logic [7:0] dat;
    logic       sop;
    logic       eop;
    logic [7:0] tag;
  } word_t;

  logic       iclk = 1'b0;
  logic       ireset = 1'b1;
  logic       iclkena = 1'b1;
  logic       ibuf_rdy = 1'b0;
  logic       ordy = 1'b1;
  logic [7:0] ilen_m1 = '0, irtag = '0, cur_base = '0;
  logic [7:0] irdat, oraddr, odat, otag, r1, r2;
  logic       orempty, oval, osop, oeop, obusy;

  // second instance with pPIPE=0 for the single-word latency case
  logic       rdy0 = 1'b0;
  logic [7:0] len0 = 8'h00, tag0 = 8'h5A;
  logic [7:0] oraddr0, odat0, otag0, r0;
  logic       orempty0, oval0, osop0, oeop0, obusy0;
  logic       one = 1'b1;

  blk_t  buf_q[$];
  word_t exp_q[$];
  int    n_vec = 0, n_err = 0, n_rel = 0;
  bit    rnd_rdy = 0, rnd_ena = 0;

  always #5 iclk = ~iclk;

  codec_buffer_rd_source #(.pRADDR_W(8), .pRDAT_W(8), .pTAG_W(8), .pPIPE(1)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ibuf_rdy(ibuf_rdy),
    .ilen_m1(ilen_m1), .oraddr(oraddr), .irdat(irdat), .irtag(irtag),
    .orempty(orempty), .ordy(ordy), .oval(oval), .osop(osop), .oeop(oeop),
    .odat(odat), .otag(otag), .obusy(obusy));

  codec_buffer_rd_source #(.pRADDR_W(8), .pRDAT_W(8), .pTAG_W(8), .pPIPE(0)) dut0 (
    .iclk(iclk), .ireset(ireset), .iclkena(one), .ibuf_rdy(rdy0),
    .ilen_m1(len0), .oraddr(oraddr0), .irdat(r0), .irtag(tag0),
    .orempty(orempty0), .ordy(one), .oval(oval0), .osop(osop0), .oeop(oeop0),
    .odat(odat0), .otag(otag0), .obusy(obusy0));

  assign irdat = r2;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic upd_buf();
    if (buf_q.size() != 0) begin
      ibuf_rdy = 1'b1;
      ilen_m1  = buf_q[0].len;
      irtag    = buf_q[0].tag;
      cur_base = buf_q[0].base;
    end else begin
      ibuf_rdy = 1'b0;
    end
  endtask

  task automatic push_block(input logic [7:0] len, input logic [7:0] tag, input logic [7:0] base);
    blk_t  b;
    word_t w;
    b.len = len; b.tag = tag; b.base = base;
    buf_q.push_back(b);
    for (int a = 0; a <= int'(len); a++) begin
      w.dat = base + 8'(a);
      w.sop = (a == 0);
      w.eop = (a == int'(len));
      w.tag = tag;
      exp_q.push_back(w);
    end
    upd_buf();
  endtask

  // RAM read port: data for the address of cycle C appears in cycle C+LAT.
  always @(posedge iclk) begin
    if (iclkena) begin
      r1 <= oraddr + cur_base;
      r2 <= r1;
    end
    r0 <= oraddr0 + 8'h77;
  end

  // Random ready / clock-enable drive, applied just after the edge.
  always @(posedge iclk) begin
    #1;
    ordy    = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    iclkena = rnd_ena ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Scoreboard and buffer release on enabled cycles.
  always @(negedge iclk) begin
    word_t e;
    if (!ireset && iclkena) begin
      if (oval && ordy) begin
        if (exp_q.size() == 0) chk("unexpected_word", 32'(oval), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("odat", 32'(odat), 32'(e.dat));
          chk("osop", 32'(osop), 32'(e.sop));
          chk("oeop", 32'(oeop), 32'(e.eop));
          if (!e.sop) chk("otag", 32'(otag), 32'(e.tag));
        end
      end
      if (orempty) begin
        n_rel++;
        if (buf_q.size() != 0) void'(buf_q.pop_front());
        upd_buf();
      end
    end
  end

  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge iclk);
      done = (buf_q.size() == 0) && (exp_q.size() == 0) && !obusy;
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  // One block with ordy=1/iclkena=1, every output checked cycle by cycle.
  task automatic run_timed(input logic [7:0] len, input logic [7:0] tag, input logic [7:0] base);
    int rel0, l;
    l = int'(len);
    @(negedge iclk);
    rel0 = n_rel;
    push_block(len, tag, base);
    for (int k = 0; k <= l + LAT + 4; k++) begin
      if (k > 0) @(negedge iclk);
      chk("t_oval", 32'(oval), 32'(k >= 2 + LAT && k <= 2 + LAT + l));
      if (k >= 2 + LAT && k <= 2 + LAT + l) chk("t_odat", 32'(odat), 32'(base + 8'(k - 2 - LAT)));
      chk("t_osop", 32'(osop), 32'(k == 2 + LAT));
      chk("t_oeop", 32'(oeop), 32'(k == 2 + LAT + l));
      chk("t_orempty", 32'(orempty), 32'(k == l + LAT + 2));
      chk("t_obusy", 32'(obusy), 32'(k >= 1 && k <= l + LAT + 3));
      if (k >= 1 && k <= l + 1) chk("t_oraddr", 32'(oraddr), 32'(k - 1));
    end
    chk("t_otag", 32'(otag), 32'(tag));
    chk("t_relcnt", 32'(n_rel - rel0), 32'd1);
  endtask

  task automatic set_random(input bit rr, input bit re);
    rnd_rdy = rr;
    rnd_ena = re;
    repeat (2) @(negedge iclk);
  endtask

  initial begin
    int rel_b, n;
    @(negedge iclk);
    chk("rst_oraddr", 32'(oraddr), 0);
    chk("rst_orempty", 32'(orempty), 0);
    chk("rst_oval", 32'(oval), 0);
    chk("rst_osop", 32'(osop), 0);
    chk("rst_oeop", 32'(oeop), 0);
    chk("rst_odat", 32'(odat), 0);
    chk("rst_otag", 32'(otag), 0);
    chk("rst_obusy", 32'(obusy), 0);
    @(negedge iclk);
    ireset = 1'b0;
    @(negedge iclk);

    // pPIPE=0 single-word block: word and release both in cycle 3
    n = 0;
    rdy0 = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge iclk);
      chk("p0_oval", 32'(oval0), 32'(k == 3));
      chk("p0_osop", 32'(osop0), 32'(k == 3));
      chk("p0_oeop", 32'(oeop0), 32'(k == 3));
      chk("p0_orempty", 32'(orempty0), 32'(k == 3));
      if (k == 3) chk("p0_odat", 32'(odat0), 32'h77);
      if (orempty0) begin n++; rdy0 = 1'b0; end
    end
    chk("p0_relcnt", 32'(n), 1);
    chk("p0_otag", 32'(otag0), 32'h5A);

    // canonical block and single-word block, pPIPE=1
    run_timed(8'd3, 8'hA5, 8'h10);
    run_timed(8'd0, 8'h3C, 8'h55);

    // three blocks back to back with ibuf_rdy held
    rel_b = n_rel;
    for (int b = 1; b <= 3; b++) push_block(8'($urandom_range(0, 7)), 8'(b), 8'($urandom));
    wait_done();
    chk("b2b_relcnt", 32'(n_rel - rel_b), 3);
    chk("b2b_otag", 32'(otag), 3);

    // full-length block under random backpressure
    set_random(1, 0);
    rel_b = n_rel;
    push_block(8'd255, 8'h42, 8'($urandom));
    wait_done();
    chk("full_relcnt", 32'(n_rel - rel_b), 1);

    // random clock enable plus backpressure, two blocks
    set_random(1, 1);
    rel_b = n_rel;
    push_block(8'd40, 8'h91, 8'($urandom));
    push_block(8'($urandom_range(0, 20)), 8'h92, 8'($urandom));
    wait_done();
    chk("ena_relcnt", 32'(n_rel - rel_b), 2);
    chk("ena_otag", 32'(otag), 32'h92);
    set_random(0, 0);

    // reset in the middle of READ
    push_block(8'd100, 8'hEE, 8'h00);
    n = 0;
    for (int i = 0; i < 200 && n == 0; i++) begin
      @(negedge iclk);
      if (oraddr >= 8'd10 && obusy) n = 1;
    end
    chk("mid_reached", 32'(n), 1);
    rel_b = n_rel;
    ireset = 1'b1;
    buf_q.delete();
    exp_q.delete();
    upd_buf();
    @(negedge iclk);
    chk("mr_oraddr", 32'(oraddr), 0);
    chk("mr_orempty", 32'(orempty), 0);
    chk("mr_oval", 32'(oval), 0);
    chk("mr_osop", 32'(osop), 0);
    chk("mr_oeop", 32'(oeop), 0);
    chk("mr_odat", 32'(odat), 0);
    chk("mr_otag", 32'(otag), 0);
    chk("mr_obusy", 32'(obusy), 0);
    chk("mr_relcnt", 32'(n_rel - rel_b), 0);
    ireset = 1'b0;
    run_timed(8'd5, 8'h77, 8'h30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors", n_vec);
    $fatal(1);
  end

endmodule

// File: doc/codec_buffer_rd_source.md
# codec_buffer_rd_source

Read-side sequencer for the banked codec DWC buffer. It waits for a complete block in the buffer and issues the read address sequence 0..ilen_m1 against the fixed-latency RAM port. It repacks the returned words into a framed stream (sop/val/eop) with ready backpressure, then releases the bank with a one-cycle irempty pulse. It sits directly downstream of the buffer and feeds the decoder/encoder core.

## Interface
- pRADDR_W, 8, buffer read address width (words per bank = 2**pRADDR_W)
- pRDAT_W, 8, read data width
- pTAG_W, 8, tag width
- pPIPE, 1, must match the buffer's pPIPE; RAM read latency LAT = 1 + pPIPE
- iclk  in  1  clock; single clock domain
- ireset  in  1  reset; synchronous, active-high
- iclkena  in  1  global clock enable; low freezes all state
- ibuf_rdy  in  1  a complete block is available; driven from buffer ~oemptya
- ilen_m1  in  pRADDR_W  block length minus 1; sampled on block start
- oraddr  out  pRADDR_W  read address to buffer iraddr
- irdat  in  pRDAT_W  buffer ordat, valid LAT cycles after oraddr
- irtag  in  pTAG_W  buffer ortag for the current read bank
- orempty  out  1  bank release pulse to buffer irempty
- ordy  in  1  downstream ready
- oval, osop, oeop  out  1 each  stream valid / first word / last word
- odat  out  pRDAT_W  stream data
- otag  out  pTAG_W  block tag, constant for the whole block
- obusy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, READ, WAIT, RELEASE, GAP.
- IDLE:
  - On ibuf_rdy=1, latch ilen_m1 and irtag into the tag register, clear the address counter, and go to READ.
  - When a block starts, mark the first issued word sop.
- READ: issue one address per cycle when credit is available.
  - Credit exists when fifo_cnt + inflight < 4, using registered counts. A pop in the same cycle is not credited.
  - Each issue drives oraddr = addr and increments addr.
  - Issuing addr == len_m1 tags that word eop and goes to WAIT.
- WAIT: hold until the last issued word has been captured into the FIFO (inflight reaches 0), then go to RELEASE.
- RELEASE: orempty=1 for exactly one cycle, then go to GAP.
- GAP: one guard cycle so the registered buffer status reflects the release, then go to IDLE. ibuf_rdy is ignored here.
- Output FIFO:
  - Depth 4. Each entry holds {sop, eop, data}.
  - Write on returned data. A write into a full FIFO is impossible by credit; flag it with an assertion.
  - oval = FIFO non-empty; a pop occurs on oval & ordy.
  - The FIFO need not drain before RELEASE, so the next block may overlap with drain of the previous one.
- otag:
  - Loads the latched tag when the first word of a block is popped with osop.
  - Held until the next block's sop pop.
- Address width: the counter is pRADDR_W bits. len_m1 = 2**pRADDR_W-1 is legal, and no wrap occurs before eop.
- iclkena=0: FSM, counters, FIFO, the inflight pipeline and the tag register are frozen. Outputs hold. Pops do not occur.
- ireset mid-block:
  - Return to IDLE and flush the FIFO and inflight tracking.
  - orempty is not issued. The buffer is reset by the same ireset.

## Timing
- Reset values:
  - All outputs: oraddr=0, orempty=0, oval=0, osop=0, oeop=0, odat=0, otag=0, obusy=0.
  - Internal state: FIFO empty, inflight=0.
- oraddr is registered. irdat for an address driven in cycle C is valid in cycle C+LAT, captured at the end of that cycle, and visible on oval in cycle C+LAT+1.
- Example with ibuf_rdy sampled in IDLE at cycle 0 and pPIPE=1:
  - addr 0 in cycle 1, irdat in cycle 3, oval/osop in cycle 4.
  - In general, first oval = 2 + LAT.
- Last address issued in cycle L: orempty in cycle L+LAT+1, GAP in cycle L+LAT+2, IDLE in cycle L+LAT+3.
- With ordy held at 1, issue rate is one word per cycle with no bubbles inside a block.
- Block-to-block overhead from the eop issue to the next addr 0 is LAT+4 cycles.

## Test plan
- pPIPE=1, ilen_m1=3, irdat=addr+0x10, irtag=0xA5, ordy=1 → oval for cycles 4..7 carrying 0x10,0x11,0x12,0x13; osop in cycle 4; oeop in cycle 7; otag=0xA5; orempty single pulse in cycle 7.
- ilen_m1=0 with pPIPE=0 and pPIPE=1 → exactly one word with osop=oeop=1; exactly one orempty pulse per block.
- ibuf_rdy held at 1 for 3 blocks with tags 1,2,3 → 3 framed blocks in order, tags change only at sop, 3 orempty pulses, no FIFO overflow assertion.
- Random ordy (50%), ilen_m1=255 → all 256 words delivered in order with no loss or duplication, fifo_cnt never exceeds 4, orempty only after the last word is captured.
- iclkena toggled randomly during a block → output sequence identical to the run with iclkena=1 (compare per-enabled-cycle); no extra orempty pulses.
- ireset asserted mid-READ → next cycle all outputs at reset values and FIFO empty; no orempty pulse; after reset the next block starts at addr 0.
